// File: rtl/ht_res_stats.sv
// Passive statistics tap on the hash-table result stream: saturating per-rescode,
// total and stall counters, snapshotted into a shadow bank read via a 1-cycle port.

module ht_res_stats_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  input  logic         snap,
  output logic [W-1:0] shadow
);
  logic [W-1:0] live;

  // Shadow captures the pre-edge live value, so events in the snap cycle land in live only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live   <= '0;
      shadow <= '0;
    end else begin
      if (snap) shadow <= live;
      if (clr)                  live <= {{(W-1){1'b0}}, inc};
      else if (inc && ~&live)   live <= live + W'(1);
    end
  end
endmodule

module ht_res_stats #(
  parameter int CNT_WIDTH     = 32,
  parameter int RESCODE_WIDTH = 3,
  parameter int CLEAR_ON_SNAP = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     result_valid_i,
  input  logic                     result_ready_i,
  input  logic [RESCODE_WIDTH-1:0] result_rescode_i,
  input  logic                     snap_i,
  input  logic                     rd_en_i,
  input  logic [3:0]               rd_addr_i,
  output logic [CNT_WIDTH-1:0]     rd_data_o,
  output logic                     rd_data_val_o,
  output logic [15:0]              snap_cnt_o
);
  localparam int NUM_CODES = 1 << RESCODE_WIDTH;

  logic accept, stall, clr;
  logic [NUM_CODES-1:0]                code_inc;
  logic [NUM_CODES-1:0][CNT_WIDTH-1:0] code_sh;
  logic [CNT_WIDTH-1:0]                total_sh, stall_sh, rd_mux;

  assign accept = result_valid_i &&  result_ready_i;
  assign stall  = result_valid_i && !result_ready_i;
  assign clr    = snap_i && (CLEAR_ON_SNAP != 0);

  for (genvar i = 0; i < NUM_CODES; i++) begin : g_code
    // Gated by accept first so an X rescode while idle never reaches the counters.
    assign code_inc[i] = accept && (result_rescode_i == RESCODE_WIDTH'(i));
    ht_res_stats_cnt #(.W(CNT_WIDTH)) u_cnt (
      .clk(clk_i), .rst_n(rst_n_i), .inc(code_inc[i]), .clr(clr), .snap(snap_i),
      .shadow(code_sh[i])
    );
  end

  ht_res_stats_cnt #(.W(CNT_WIDTH)) u_total (
    .clk(clk_i), .rst_n(rst_n_i), .inc(accept), .clr(clr), .snap(snap_i), .shadow(total_sh)
  );
  ht_res_stats_cnt #(.W(CNT_WIDTH)) u_stall (
    .clk(clk_i), .rst_n(rst_n_i), .inc(stall), .clr(clr), .snap(snap_i), .shadow(stall_sh)
  );

  always_comb begin
    rd_mux = '0;
    if (32'(rd_addr_i) < NUM_CODES) rd_mux = code_sh[rd_addr_i[RESCODE_WIDTH-1:0]];
    else if (rd_addr_i == 4'd8)     rd_mux = total_sh;
    else if (rd_addr_i == 4'd9)     rd_mux = stall_sh;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_o     <= '0;
      rd_data_val_o <= 1'b0;
      snap_cnt_o    <= '0;
    end else begin
      rd_data_val_o <= rd_en_i;
      if (rd_en_i) rd_data_o  <= rd_mux;
      if (snap_i)  snap_cnt_o <= snap_cnt_o + 16'd1;
    end
  end
endmodule

// File: doc/ht_res_stats.md
Name: ht_res_stats

Overview:
- Passive statistics tap on the hash-table result stream (`ht_res_out`), directly downstream of `hash_table_top`, alongside the result consumer.
- Counts accepted results per result code, total results and backpressure stall cycles.
- Periodically snapshots the counters into a shadow bank, read through a simple registered read port.
- Never drives `ready` and never alters the stream.

Parameters:
- CNT_WIDTH, 32, width of every live and shadow counter.
- RESCODE_WIDTH, 3, width of the result-code field; one counter per code (2**RESCODE_WIDTH counters).
- CLEAR_ON_SNAP, 1, 1 = live counters restart from zero at snapshot; 0 = live counters keep running.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- result_valid_i  in  1  `ht_res_out.valid`.
- result_ready_i  in  1  `ht_res_out.ready`.
- result_rescode_i  in  RESCODE_WIDTH  rescode of the current result.
- snap_i  in  1  single-cycle snapshot request.
- rd_en_i  in  1  read strobe.
- rd_addr_i  in  4  read address.
- rd_data_o  out  CNT_WIDTH  read data.
- rd_data_val_o  out  1  read data valid.
- snap_cnt_o  out  16  number of snapshots taken; wraps modulo 2**16.

Behaviour:
- Reset (async assert, sync release): all live counters, shadow counters, snap_cnt_o, rd_data_o and rd_data_val_o = 0.
- Accept event: result_valid_i && result_ready_i in a cycle.
  - live_code[result_rescode_i] += 1.
  - live_total += 1.
- Stall event: result_valid_i && !result_ready_i; live_stall += 1.
- Accept and stall are mutually exclusive. Inputs are ignored when valid is low. X on rescode while valid is low must not propagate.
- Saturation: every counter saturates at all-ones and never wraps. Saturated counters still clear on snapshot when CLEAR_ON_SNAP=1.
- Snapshot, snap_i=1 in cycle N:
  - Shadow bank <= live values as of the start of cycle N; cycle-N events are excluded.
  - snap_cnt_o += 1 at the edge ending cycle N.
  - CLEAR_ON_SNAP=1: each live counter <= (event in N ? 1 : 0).
  - CLEAR_ON_SNAP=0: live counters update normally.
  - Back-to-back snap_i on consecutive cycles: each is honoured independently.
- Read port:
  - rd_en_i in cycle N -> rd_data_val_o=1 and rd_data_o valid in cycle N+1 (registered, latency 1).
  - rd_data_val_o=0 otherwise; rd_data_o holds its last value.
  - Reads return shadow only, never live.
  - A read and a snap in the same cycle N return the shadow value before the cycle-N snapshot.
  - Back-to-back reads are supported at one per cycle.
- Address map:
  - 0..2**RESCODE_WIDTH-1: shadow_code[addr].
  - 8: shadow_total.
  - 9: shadow_stall.
  - 10..15: read as 0, with rd_data_val_o still 1.
- Invariant: shadow_total == sum of shadow_code, unless any counter has saturated.
- Reset asserted mid-operation: all state clears immediately. A read pending at reset assertion is dropped; no rd_data_val_o pulse after release.
- No state machine beyond the counter/shadow registers and the one-stage read pipeline. Combinational path from result inputs limited to the counter increment logic.

Test Plan:
- Reset, then read addresses 0..15 -> 16 rd_data_val_o pulses, each one cycle after its rd_en_i, all data 0.
- Accept 3 results with rescode 2 and 1 with rescode 5 at ready=1, snap, read -> addr2=3, addr5=1, addr8=4, addr9=0; snap_cnt_o=1.
- Hold valid=1, ready=0 for 7 cycles, then accept 1 result (rescode 0), snap -> addr9=7, addr8=1, addr0=1.
- CLEAR_ON_SNAP=1: snap in the same cycle as an accept of rescode 4 after 2 prior rescode-4 accepts -> shadow addr4=2; second snap with no traffic -> addr4=1.
- CNT_WIDTH=4: 20 accepts of rescode 1, snap -> addr1=15 and addr8=15 (saturated). rd_en_i in the same cycle as snap_i returns the previous shadow value.
- Assert rst_n_i low mid-traffic, with a read issued in the same cycle -> no rd_data_val_o pulse; all shadows read 0 after release; snap_cnt_o=0.
